// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline constants and the IF/ID payload type.
// The ID/EX register reuses the same payload type.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: a valid bit plus a payload register.
// Clear has priority over load, and a cleared slot holds ClearVal.
module pipe_slot #(
    parameter int unsigned      Width    = 64,
    parameter logic [Width-1:0] ClearVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = ClearVal;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= ClearVal;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and NOP presentation on empty slots.
module if_id_stage_reg #(
    parameter int unsigned     XLEN     = rv32_pkg::XLEN,
    parameter int unsigned     ILEN     = rv32_pkg::ILEN,
    parameter logic [ILEN-1:0] NOP_INSN = rv32_pkg::NOP_INSN,
    parameter bit              SKID_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [1:0]      occupancy
);

    localparam int unsigned W = ILEN + XLEN;
    localparam logic [W-1:0] ClearVal = {NOP_INSN, {XLEN{1'b0}}};

    logic         in_fire, drain, main_free;
    logic         main_valid, skid_valid;
    logic [W-1:0] main_data, skid_data, in_data, main_din;
    logic         main_load, main_clr, skid_load, skid_clr;
    logic         main_valid_d, skid_valid_d;
    logic [1:0]   occupancy_d, occupancy_q;

    assign in_data   = {in_instr, in_pc};
    assign in_fire   = in_valid & in_ready;
    assign drain     = main_valid & out_ready;
    assign main_free = ~main_valid | drain;

    // Steering: main refills from skid first so order stays main-before-skid.
    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_din  = in_data;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (main_free) begin
            if (skid_valid) begin
                main_load = 1'b1;
                main_din  = skid_data;
                if (in_fire) begin
                    skid_load = 1'b1;
                end else begin
                    skid_clr = 1'b1;
                end
            end else if (in_fire) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (in_fire) begin
            skid_load = 1'b1;
        end
    end

    always_comb begin
        main_valid_d = main_clr ? 1'b0 : (main_load ? 1'b1 : main_valid);
        skid_valid_d = 1'b0;
        if (SKID_EN) begin
            skid_valid_d = skid_clr ? 1'b0 : (skid_load ? 1'b1 : skid_valid);
        end
        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    pipe_slot #(
        .Width    (W),
        .ClearVal (ClearVal)
    ) u_main (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_din),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    if (SKID_EN) begin : g_skid
        logic in_ready_q;

        pipe_slot #(
            .Width    (W),
            .ClearVal (ClearVal)
        ) u_skid (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .load_i  (skid_load),
            .clear_i (skid_clr),
            .data_i  (in_data),
            .valid_o (skid_valid),
            .data_o  (skid_data)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= ~skid_valid_d;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_no_skid
        assign skid_valid = 1'b0;
        assign skid_data  = ClearVal;
        assign in_ready   = ~main_valid | out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_q <= 2'd0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign out_valid = main_valid;
    assign out_instr = main_data[W-1:XLEN];
    assign out_pc    = main_data[XLEN-1:0];
    assign occupancy = occupancy_q;

    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready && !flush) |=>
        (!in_valid || ($stable(in_instr) && $stable(in_pc))));

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= (SKID_EN ? 2'd2 : 2'd1));

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: a skid-buffered and a plain instance, a vector table of
// per-cycle expectations and a FIFO scoreboard for the {instr, pc} stream.
module tb_if_id_stage_reg;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_valid0 = 1'b0, out_ready0 = 1'b0;

    logic        in_ready, out_valid, in_ready0, out_valid0;
    logic [31:0] out_instr, out_pc, out_instr0, out_pc0;
    logic [1:0]  occupancy, occupancy0;

    int errors = 0;
    int checks = 0;

    logic        o_ir, o_ov;
    logic [1:0]  o_occ;
    logic [31:0] o_pc, o_instr;
    if_id_t      sb_q[$];

    always #5 clk = ~clk;

    if_id_stage_reg #(.SKID_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .occupancy (occupancy)
    );

    if_id_stage_reg #(.SKID_EN(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_instr (out_instr0),
        .out_pc    (out_pc0),
        .occupancy (occupancy0)
    );

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return 32'h0050_0093 + (pc << 5);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 after sampling at the negedge.
    task automatic step(input bit plain, input bit iv, input bit orr, input bit fl,
                        input logic [31:0] pc);
        logic oreq, ivs, flq;
        if (plain) begin
            in_valid0 = iv; out_ready0 = orr; in_valid = 1'b0; out_ready = 1'b1;
        end else begin
            in_valid = iv; out_ready = orr; in_valid0 = 1'b0; out_ready0 = 1'b1;
        end
        flush    = fl;
        in_pc    = pc;
        in_instr = insn_of(pc);
        @(negedge clk);
        o_ir    = plain ? in_ready0   : in_ready;
        o_ov    = plain ? out_valid0  : out_valid;
        o_occ   = plain ? occupancy0  : occupancy;
        o_pc    = plain ? out_pc0     : out_pc;
        o_instr = plain ? out_instr0  : out_instr;
        oreq = orr; ivs = iv; flq = fl;
        chk("sb.out_valid", 64'(o_ov), 64'(sb_q.size() != 0));
        chk("sb.occupancy", 64'(o_occ), 64'(sb_q.size()));
        if (!o_ov) begin
            chk("sb.idle_nop", {o_instr, o_pc}, {NOP_INSN, 32'h0});
        end else if (oreq && sb_q.size() != 0) begin
            chk("sb.data", {o_instr, o_pc}, {sb_q[0].instr, sb_q[0].pc});
            void'(sb_q.pop_front());
        end
        if (flq) sb_q.delete();
        if (ivs && o_ir && !flq) sb_q.push_back('{instr: insn_of(pc), pc: pc});
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          plain, iv, orr, fl;
        logic [31:0] pc;
        bit          e_ir, e_ov;
        logic [1:0]  e_occ;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit plain, bit iv, bit orr, bit fl, logic [31:0] pc,
                               bit e_ir, bit e_ov, logic [1:0] e_occ, logic [31:0] e_pc);
        vec_t r;
        r.plain = plain; r.iv = iv; r.orr = orr; r.fl = fl; r.pc = pc;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_occ = e_occ; r.e_pc = e_pc;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming, skid DUT
        vecs.push_back(v(0, 1, 1, 0, 32'h000, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 1, 1, 0, 32'h004, 1, 1, 1, 32'h000));
        vecs.push_back(v(0, 1, 1, 0, 32'h008, 1, 1, 1, 32'h004));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 1, 1, 32'h008));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 0, 0, 32'h000));
        // Back-pressure: two accepted, third held, then released in order
        vecs.push_back(v(0, 1, 0, 0, 32'h010, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 1, 0, 0, 32'h014, 1, 1, 1, 32'h010));
        vecs.push_back(v(0, 1, 0, 0, 32'h018, 0, 1, 2, 32'h010));
        vecs.push_back(v(0, 1, 1, 0, 32'h018, 0, 1, 2, 32'h010));
        vecs.push_back(v(0, 1, 1, 0, 32'h018, 1, 1, 1, 32'h014));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 1, 1, 32'h018));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 0, 0, 32'h000));
        // Flush with full stage, back-to-back flushes, flush discards accepted input
        vecs.push_back(v(0, 1, 0, 0, 32'h020, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 1, 0, 0, 32'h024, 1, 1, 1, 32'h020));
        vecs.push_back(v(0, 1, 0, 1, 32'h100, 0, 1, 2, 32'h020));
        vecs.push_back(v(0, 0, 0, 1, 32'h000, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 1, 0, 1, 32'h104, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h000));
        // Flush and drain in the same cycle, then a fresh input
        vecs.push_back(v(0, 1, 1, 0, 32'h030, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 0, 1, 1, 32'h000, 1, 1, 1, 32'h030));
        vecs.push_back(v(0, 1, 1, 0, 32'h200, 1, 0, 0, 32'h000));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 1, 1, 32'h200));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 0, 0, 32'h000));
        // Plain register: combinational in_ready, accept-while-drain
        vecs.push_back(v(1, 1, 1, 0, 32'h040, 1, 0, 0, 32'h000));
        vecs.push_back(v(1, 1, 1, 0, 32'h044, 1, 1, 1, 32'h040));
        vecs.push_back(v(1, 1, 1, 0, 32'h048, 1, 1, 1, 32'h044));
        vecs.push_back(v(1, 1, 0, 0, 32'h04c, 0, 1, 1, 32'h048));
        vecs.push_back(v(1, 1, 1, 0, 32'h04c, 1, 1, 1, 32'h048));
        vecs.push_back(v(1, 0, 1, 0, 32'h000, 1, 1, 1, 32'h04c));
        vecs.push_back(v(1, 0, 1, 0, 32'h000, 1, 0, 0, 32'h000));

        // Async reset takes effect without a clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_instr", 64'(out_instr), 64'h13);
        chk("rst.out_pc", 64'(out_pc), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.occupancy", 64'(occupancy), 64'd0);
        chk("rst.plain_occupancy", 64'(occupancy0), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].plain, vecs[i].iv, vecs[i].orr, vecs[i].fl, vecs[i].pc);
            chk($sformatf("v%0d.in_ready", i), 64'(o_ir), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d.out_valid", i), 64'(o_ov), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d.occupancy", i), 64'(o_occ), 64'(vecs[i].e_occ));
            chk($sformatf("v%0d.out_pc", i), 64'(o_pc), 64'(vecs[i].e_pc));
        end

        // Reset mid-transfer: stored entry dropped immediately
        step(0, 1, 0, 0, 32'h050);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.out_instr", 64'(out_instr), 64'h13);
        chk("midrst.out_pc", 64'(out_pc), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        chk("midrst.occupancy", 64'(occupancy), 64'd0);
        sb_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 1, 0, 32'h000);
        chk("postrst.out_valid", 64'(o_ov), 64'd0);
        chk("postrst.in_ready", 64'(o_ir), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
